// File: rtl/ram_burst_reader.sv
// Burst read client for a 1-cycle-latency synchronous RAM read port.
// Read data lands in a 2-entry skid buffer and leaves on a valid/ready stream.
module ram_burst_reader #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  issue_rem_q;
  logic [LEN_WIDTH-1:0]  beat_rem_q;
  logic                  inflight_q;
  logic [1:0]            count_q;
  logic [1:0]            count_d;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [1:0]            pending;

  always_comb begin
    push      = inflight_q;
    out_valid = (count_q != 2'd0);
    pop       = out_valid && out_ready;
    pending   = count_q + {1'b0, inflight_q};
    // A read may be issued into a full pipeline only if a beat leaves this same cycle.
    issue     = (state_q == S_RUN) && (issue_rem_q != '0) &&
                ((pending < 2'd2) || ((pending == 2'd2) && pop));
    out_last  = out_valid && (beat_rem_q == LEN_WIDTH'(1));
    out_data  = buf_q[rd_ptr_q];
    rd_en     = issue;
    rd_addr   = addr_q;
    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_FIN);
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      issue_rem_q <= '0;
      beat_rem_q  <= '0;
      inflight_q  <= 1'b0;
      count_q     <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      inflight_q <= issue;
      count_q    <= count_d;
      if (push) begin
        buf_q[wr_ptr_q] <= rd_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end

      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q      <= cmd_addr;
            issue_rem_q <= cmd_len;
            beat_rem_q  <= cmd_len;
            state_q     <= (cmd_len == '0) ? S_FIN : S_RUN;
          end
        end
        S_RUN: begin
          if (issue) begin
            addr_q      <= addr_q + ADDR_WIDTH'(1);
            issue_rem_q <= issue_rem_q - LEN_WIDTH'(1);
          end
          if (pop) begin
            beat_rem_q <= beat_rem_q - LEN_WIDTH'(1);
            if (beat_rem_q == LEN_WIDTH'(1)) begin
              state_q <= S_FIN;
            end
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ram_burst_reader.md
# ram_burst_reader

Read-side client for the single-clock 1-write/1-read-synchronous RAM macro. It accepts a burst command (start address, word count) and issues `rd_en`/`rd_addr` to the RAM read port. It absorbs the RAM's one-cycle read latency in a 2-entry skid buffer and delivers the words on a valid/ready stream with a last flag. It sits between a DMA/debug engine and any RAM whose write side is owned by another agent.

## Interface
- `ADDR_WIDTH`, 5, RAM address width; must equal the RAM's `rdAddressWidth`.
- `DATA_WIDTH`, 32, RAM read data width.
- `LEN_WIDTH`, ADDR_WIDTH+1, burst length field width; allows a full-memory burst of 2^ADDR_WIDTH.

Ports:
- `clk`  in  1  single clock; the RAM's `rd_clk` must be driven from this same clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  burst command valid.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_addr`  in  ADDR_WIDTH  first word address.
- `cmd_len`  in  LEN_WIDTH  number of words to read; 0 is legal.
- `rd_en`  out  1  RAM read enable.
- `rd_addr`  out  ADDR_WIDTH  RAM read address.
- `rd_data`  in  DATA_WIDTH  RAM read data, valid the cycle after `rd_en`.
- `out_valid`  out  1  stream beat valid.
- `out_ready`  in  1  stream sink ready.
- `out_data`  out  DATA_WIDTH  beat data.
- `out_last`  out  1  final beat of the burst.
- `busy`  out  1  burst in progress.
- `done`  out  1  one-cycle pulse on burst completion.

## Operation
- States:
  - IDLE: `cmd_ready`=1. On command handshake, latch addr/len and go to RUN. With `cmd_len`=0, go instead to FIN.
  - RUN: issue reads and stream beats. On the handshake of the beat with `out_last`, go to FIN.
  - FIN: `done`=1 for one cycle, then go to IDLE.
- Counters:
  - `issue_rem` counts reads not yet issued.
  - `beat_rem` counts beats not yet handshaken.
  - `inflight` is 1 in the cycle after `rd_en`.
  - `count` is buffer occupancy, 0..2.
- Issue rule, evaluated each cycle in RUN: `rd_en` = `issue_rem`≠0 AND (`count`+`inflight`<2 OR (`count`+`inflight`=2 AND `out_valid && out_ready`)). The buffer therefore never overflows.
- On each `rd_en`:
  - `rd_addr` advances by 1 modulo 2^ADDR_WIDTH; wrap from max address to 0 is silent.
  - `issue_rem` decrements.
- When `inflight`=1, `rd_data` is written into the buffer on that clock edge. The RAM's `rd_data` is never relied on to hold past one cycle.
- Stream output:
  - `out_data` is the buffer head.
  - `out_valid` = `count`≠0.
  - `out_last` = `out_valid` AND `beat_rem`=1.
  - `out_data` and `out_last` stay stable while `out_valid && !out_ready`.
- Simultaneous push and pop leaves `count` unchanged and preserves order.
- `busy` = state≠IDLE.
- `cmd_addr` and `cmd_len` are ignored outside a handshake.
- `cmd_len` > 2^ADDR_WIDTH is legal: addresses wrap and words repeat.
- Reset (async, any time, including mid-burst):
  - state IDLE, all counters 0, buffer emptied.
  - `rd_en`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0, `cmd_ready`=1, `rd_addr`=0, `out_data`=0.
  - Any in-flight read data is discarded.
- No write-port interaction. Read-under-write of the same address is don't-care, matching the RAM.

## Timing
- Let E0 be the command-handshake edge.
  - `rd_en` for `cmd_addr` is high in the cycle after E0 (C1).
  - Data is buffered at E2.
  - First `out_valid` is in C3, 3 cycles after the handshake.
- With `out_ready` held high, one beat per cycle; an N-word burst's last beat appears in C(N+2).
- Backpressure: at most 2 reads outstanding plus buffered. When `out_ready` rises, `rd_en` resumes in the same cycle.
- Last-beat handshake at edge Ek:
  - `done`=1 in cycle k+1.
  - `cmd_ready`=1 from cycle k+2.
- `cmd_len`=0: `done` in the cycle after E0, with no `rd_en` and no beats.

## Test plan
- **Basic burst:** preload RAM[i]=0x100+i; cmd addr=4, len=3, `out_ready`=1 → `rd_en` in C1..C3 with addr 4,5,6; beats 0x104,0x105,0x106 in C3..C5; `out_last` on 0x106; `done` in C6.
- **Wrap:** ADDR_WIDTH=5, cmd addr=30, len=4 → `rd_addr` sequence 30,31,0,1; data RAM[30],RAM[31],RAM[0],RAM[1].
- **Backpressure:** len=8, `out_ready` toggling 1,0,0,1,… pseudo-randomly → all 8 words in order, no loss or duplication; `rd_en` never raises occupancy above 2; `out_data` stable during stalls.
- **Zero length:** cmd len=0 → no `rd_en`, no `out_valid`, `done` pulse in C1, `cmd_ready` back in C2.
- **Full memory:** len=32 with `out_ready`=1 → 32 consecutive beats, last beat in C34, `out_last` exactly once.
- **Reset mid-burst:** assert `rst_n`=0 after the 2nd beat of a len=6 burst → immediately `out_valid`=0, `busy`=0, `cmd_ready`=1; after release, a new cmd addr=0, len=2 returns RAM[0],RAM[1] with no stale data.
